// File: rtl/siso_shift_engine_if.sv
// rtl/siso_shift_engine_if.sv - load handshake and serial link bundle for siso_shift_engine
interface siso_shift_engine_if #(
  parameter int WIDTH = 16
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             Load_valid;
  logic             Load_ready;
  logic [WIDTH-1:0] A;
  logic             Left;
  logic             Rotate;
  logic             Din;
  logic             Stall;
  logic             Dout;
  logic             Dout_valid;
  logic             Done;
  logic             Busy;
  logic [WIDTH-1:0] Q;
  logic [CNT_W-1:0] Bit_cnt;

  modport master (
    output Load_valid, A, Left, Rotate, Din, Stall,
    input  Load_ready, Dout, Dout_valid, Done, Busy, Q, Bit_cnt
  );

  modport slave (
    input  Load_valid, A, Left, Rotate, Din, Stall,
    output Load_ready, Dout, Dout_valid, Done, Busy, Q, Bit_cnt
  );
endinterface

// File: rtl/siso_shift_engine.sv
// rtl/siso_shift_engine.sv - parallel-load serial shift engine with stall, rotate and frame counter
module siso_shift_engine #(
  parameter int WIDTH = 16
) (
  input logic                  Clk,
  input logic                  Rst,
  siso_shift_engine_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] bit_cnt;
  logic             dir;
  logic             rot;
  logic             dout;
  logic             dout_valid;
  logic             done;
  logic             load_ready;
  logic             busy;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      q          <= '0;
      bit_cnt    <= '0;
      dir        <= 1'b0;
      rot        <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Load_valid) begin
            q          <= bus.A;
            dir        <= bus.Left;
            rot        <= bus.Rotate;
            bit_cnt    <= CNT_W'(WIDTH);
            state      <= SHIFT;
            load_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          if (!bus.Stall) begin
            if (dir) begin
              dout <= q[WIDTH-1];
              q    <= {q[WIDTH-2:0], rot ? q[WIDTH-1] : bus.Din};
            end else begin
              dout <= q[0];
              q    <= {rot ? q[0] : bus.Din, q[WIDTH-1:1]};
            end
            dout_valid <= 1'b1;
            bit_cnt    <= bit_cnt - CNT_W'(1);
            // Ready rises with Done so the producer can offer the next word immediately.
            if (bit_cnt == CNT_W'(1)) begin
              done       <= 1'b1;
              state      <= IDLE;
              load_ready <= 1'b1;
              busy       <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Load_ready = load_ready;
  assign bus.Busy       = busy;
  assign bus.Dout       = dout;
  assign bus.Dout_valid = dout_valid;
  assign bus.Done       = done;
  assign bus.Q          = q;
  assign bus.Bit_cnt    = bit_cnt;
endmodule
